servo_pwm: RTL and testbench
============================

# servo_pwm

Servo PWM generator: the producer of the `s_pulse` line that the servo motion controller forwards to the `SERVO` pin, driven by the 19-bit `s_duty` that controller ramps. Once per frame it latches and clamps the requested duty, then emits one high pulse of exactly that many clock cycles. It also reports frame boundaries, clamping, and a settled indication for the sequencing logic.

## Interface
- `PERIOD`, 2000000: frame length in clk cycles (20 ms at 100 MHz).
- `DUTY_MIN`, 72000: lowest legal pulse width in cycles (0°).
- `DUTY_MAX`, 253000: highest legal pulse width in cycles (180°). Must satisfy 0 < DUTY_MIN ≤ DUTY_MAX < PERIOD.
- `SETTLE_FRAMES`, 25: consecutive identical frames required for `settled`. Must be ≥ 1.

Ports:
- `clk`  in  1  system clock. One clock; reset is asynchronous and active-high.
- `reset`  in  1  asynchronous, active-high reset.
- `enable`  in  1  level-sensitive; 1 = generate frames.
- `s_duty`  in  19  requested pulse width in cycles. May change on any cycle.
- `s_pulse`  out  1  PWM output, registered.
- `frame_start`  out  1  one-cycle strobe on the first cycle of each frame.
- `duty_active`  out  19  clamped duty latched for the current frame.
- `clamped`  out  1  1 while the current frame's duty was clamped.
- `settled`  out  1  1 while duty has been constant for ≥ SETTLE_FRAMES frames.

## Operation
- Frame counter `cnt` (width ceil(log2(PERIOD))) counts 0..PERIOD-1 and wraps to 0 while enabled.
- Frame start is the cycle with cnt==0 while enabled. In that cycle:
  - `frame_start`=1.
  - `duty_active` = clamp(`s_duty`): below DUTY_MIN gives DUTY_MIN, above DUTY_MAX gives DUTY_MAX, otherwise unchanged. The compare is unsigned, full 19-bit.
  - `clamped` is set if clamping occurred; otherwise cleared.
- `s_duty` is sampled only at frame start. Changes mid-frame take effect at the next frame and never alter a pulse in progress.
- `s_pulse` is high for exactly `duty_active` consecutive cycles. The pulse begins in the `frame_start` cycle. `s_pulse` is low for the rest of the frame.
- Settle counter (saturating at SETTLE_FRAMES), evaluated at each frame start:
  - The first frame after enable or reset loads 1.
  - If the new latched duty equals the previous `duty_active`, the counter increments.
  - Otherwise it loads 1.
  - `settled` = (counter == SETTLE_FRAMES), updated in the same frame_start cycle.
- `enable` low:
  - `cnt` is held at 0.
  - `s_pulse`, `frame_start` and `settled` are 0, and the settle counter is cleared.
  - `duty_active` and `clamped` hold their last values.
- `enable` falling mid-frame, including mid-pulse: `s_pulse` goes low on the next edge. The partial frame is abandoned.
- `enable` rising: the first edge that samples `enable`=1 makes `frame_start`=1 (cnt=0) visible in the following cycle.

## Timing
- Reset (asynchronous): cnt=0, `s_pulse`=0, `frame_start`=0, `duty_active`=0, `clamped`=0, `settled`=0, settle counter 0.
- After reset deassertion, enabled operation behaves exactly as an `enable` rising edge.
- Reset asserted mid-pulse: `s_pulse` drops immediately (asynchronous).
- All outputs are registered; there is no combinational path from inputs to outputs.
- Latency: `enable` sampled high to first `frame_start`/`s_pulse` high is one edge.
- While enabled, `frame_start` pulses exactly every PERIOD cycles.
- `settled` and `clamped` change only on frame_start cycles, on enable fall, or on reset.

## Test plan
Bench parameters: PERIOD=100, DUTY_MIN=10, DUTY_MAX=90, SETTLE_FRAMES=3.
- Reset asserted asynchronously mid-pulse with `enable`=1, `s_duty`=40 -> all outputs 0 immediately. After release, `frame_start` one edge later, then a 40-cycle pulse.
- `s_duty`=40, `enable`=1 for 5 frames -> `frame_start` every 100 cycles, `s_pulse` high 40 cycles starting with the `frame_start` cycle, `duty_active`=40, `clamped`=0.
- `s_duty` changed 40→60 at cnt=20 -> current pulse stays 40 cycles, next frame pulse 60 cycles, `duty_active` updates at that frame_start.
- `s_duty`=5 -> pulse 10 cycles, `clamped`=1. Then `s_duty`=300 -> pulse 90 cycles, `clamped`=1. Then `s_duty`=10 -> pulse 10 cycles, `clamped`=0.
- Constant `s_duty`=40 from enable -> `settled` rises at the 3rd frame_start. `s_duty`→41 -> `settled` falls at the next frame_start and re-rises two frames later.
- `enable` dropped at cnt=15 with `duty_active`=40 -> `s_pulse` low next edge, `settled`=0, `duty_active` held at 40. Re-enable -> `frame_start` one edge later with a fresh latch.

Source files
------------

// File: rtl/servo_pwm.sv
// Servo PWM generator: latches a clamped duty once per frame and emits a single
// pulse of that many cycles, with frame strobe, clamp flag and settle indication.
module servo_pwm #(
   parameter int PERIOD        = 2000000,
   parameter int DUTY_MIN      = 72000,
   parameter int DUTY_MAX      = 253000,
   parameter int SETTLE_FRAMES = 25
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        enable_i,
   input  logic [18:0] s_duty_i,
   output logic        s_pulse_o,
   output logic        frame_start_o,
   output logic [18:0] duty_active_o,
   output logic        clamped_o,
   output logic        settled_o
);

   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int SW = $clog2(SETTLE_FRAMES + 1);
   localparam int XW = (CW > 19) ? CW : 19;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] settle_q, settle_d;
   logic          pulse_q, pulse_d;
   logic          fs_q, fs_d;
   logic [18:0]   duty_q, duty_d;
   logic          clamped_q, clamped_d;
   logic          settled_q, settled_d;

   logic          at_start;
   logic [18:0]   duty_new;
   logic          duty_clip;

   always_comb begin
      duty_new  = s_duty_i;
      duty_clip = 1'b0;
      if (s_duty_i < 19'(DUTY_MIN)) begin
         duty_new  = 19'(DUTY_MIN);
         duty_clip = 1'b1;
      end else if (s_duty_i > 19'(DUTY_MAX)) begin
         duty_new  = 19'(DUTY_MAX);
         duty_clip = 1'b1;
      end
   end

   // cnt_q == 0 with enable high is the edge that opens a frame; all outputs
   // are computed for the cycle that follows this edge.
   assign at_start = enable_i && (cnt_q == '0);

   always_comb begin
      cnt_d     = '0;
      fs_d      = 1'b0;
      pulse_d   = 1'b0;
      duty_d    = duty_q;
      clamped_d = clamped_q;
      settle_d  = '0;
      settled_d = 1'b0;
      if (enable_i) begin
         cnt_d     = (cnt_q == CW'(PERIOD - 1)) ? '0 : cnt_q + CW'(1);
         fs_d      = at_start;
         settle_d  = settle_q;
         settled_d = settled_q;
         if (at_start) begin
            duty_d    = duty_new;
            clamped_d = duty_clip;
            if (settle_q == '0 || duty_new != duty_q)
               settle_d = SW'(1);
            else if (settle_q != SW'(SETTLE_FRAMES))
               settle_d = settle_q + SW'(1);
            settled_d = (settle_d == SW'(SETTLE_FRAMES));
         end
         pulse_d = (XW'(cnt_q) < XW'(duty_d));
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_q     <= '0;
         fs_q      <= 1'b0;
         pulse_q   <= 1'b0;
         duty_q    <= '0;
         clamped_q <= 1'b0;
         settle_q  <= '0;
         settled_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         fs_q      <= fs_d;
         pulse_q   <= pulse_d;
         duty_q    <= duty_d;
         clamped_q <= clamped_d;
         settle_q  <= settle_d;
         settled_q <= settled_d;
      end
   end

   assign s_pulse_o     = pulse_q;
   assign frame_start_o = fs_q;
   assign duty_active_o = duty_q;
   assign clamped_o     = clamped_q;
   assign settled_o     = settled_q;

endmodule

// File: tb/tb_servo_pwm.sv
// Self-checking bench for servo_pwm: directed scenarios plus randomized traffic
// compared against a frame-level behavioural model.
module tb_servo_pwm;

   localparam int P  = 100;
   localparam int DMIN = 10;
   localparam int DMAX = 90;
   localparam int SF = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en  = 1'b0;
   logic [18:0] s_duty = 19'd40;
   logic        s_pulse, frame_start, clamped, settled;
   logic [18:0] duty_active;

   int n_cmp = 0;
   int n_bad = 0;

   servo_pwm #(.PERIOD(P), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX), .SETTLE_FRAMES(SF)) dut (
      .clk_i(clk), .reset_i(rst), .enable_i(en), .s_duty_i(s_duty),
      .s_pulse_o(s_pulse), .frame_start_o(frame_start), .duty_active_o(duty_active),
      .clamped_o(clamped), .settled_o(settled)
   );

   always #5 clk = ~clk;

   // Behavioural model: position within the frame (-1 = idle), frame-start latch.
   int m_pos = -1, m_duty = 0, m_scount = 0;
   bit m_pulse = 0, m_fs = 0, m_clamped = 0, m_settled = 0;

   always @(posedge clk or posedge rst) begin
      int c;
      if (rst) begin
         m_pos = -1; m_duty = 0; m_scount = 0;
         m_pulse = 0; m_fs = 0; m_clamped = 0; m_settled = 0;
      end else if (!en) begin
         m_pos = -1; m_pulse = 0; m_fs = 0; m_settled = 0; m_scount = 0;
      end else begin
         m_pos = (m_pos < 0 || m_pos == P - 1) ? 0 : m_pos + 1;
         m_fs = (m_pos == 0);
         if (m_fs) begin
            c = int'(s_duty);
            c = (c < DMIN) ? DMIN : (c > DMAX) ? DMAX : c;
            if (m_scount == 0 || c != m_duty) m_scount = 1;
            else if (m_scount < SF) m_scount = m_scount + 1;
            m_clamped = (c != int'(s_duty));
            m_duty = c;
            m_settled = (m_scount == SF);
         end
         m_pulse = (m_pos < m_duty);
      end
   end

   // Observes one frame starting at the current (frame_start) negedge; ends on
   // the negedge of the following frame's first cycle.
   task automatic measure_frame(input int chg_at, input logic [18:0] chg_val,
                                output int hi, output bit contig,
                                output int extra_fs, output bit next_fs);
      bit seen_low = 0;
      hi = 0; contig = 1; extra_fs = 0;
      for (int i = 0; i < P; i++) begin
         if (i > 0) @(negedge clk);
         if (chg_at == i) s_duty = chg_val;
         if (s_pulse) begin
            hi++;
            if (seen_low) contig = 0;
         end else seen_low = 1;
         if (i > 0 && frame_start) extra_fs++;
      end
      @(negedge clk);
      next_fs = frame_start;
   endtask

   task automatic test_reset();
      int hi, xf; bit ct, nf;
      rst = 1; en = 0; s_duty = 19'd40;
      repeat (3) @(negedge clk);
      n_cmp++; if ({s_pulse, frame_start, clamped, settled} !== 4'b0) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {s_pulse, frame_start, clamped, settled}); end
      n_cmp++; if (duty_active !== 19'd0) begin n_bad++; $display("FAIL reset_duty got %0d want 0", duty_active); end
      rst = 0; en = 1;
      @(negedge clk);
      n_cmp++; if ({frame_start, s_pulse} !== 2'b11) begin n_bad++; $display("FAIL first_frame fs/pulse got %b want 11", {frame_start, s_pulse}); end
      repeat (19) @(negedge clk);
      #2 rst = 1;
      #1;
      n_cmp++; if ({s_pulse, frame_start, clamped, settled} !== 4'b0 || duty_active !== 19'd0) begin
         n_bad++; $display("FAIL async_reset got pulse=%b fs=%b cl=%b st=%b duty=%0d want all 0", s_pulse, frame_start, clamped, settled, duty_active);
      end
      @(negedge clk);
      rst = 0;
      @(negedge clk);
      n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL post_reset_fs got %b want 1", frame_start); end
      measure_frame(-1, 19'd0, hi, ct, xf, nf);
      n_cmp++; if (hi !== 40 || !ct) begin n_bad++; $display("FAIL post_reset_width got %0d contig=%0b want 40 contig=1", hi, ct); end
   endtask

   task automatic test_steady();
      int hi, xf; bit ct, nf;
      for (int f = 0; f < 5; f++) begin
         n_cmp++; if (duty_active !== 19'd40 || clamped !== 1'b0) begin n_bad++; $display("FAIL steady_latch f%0d got duty=%0d cl=%b want 40/0", f, duty_active, clamped); end
         measure_frame(-1, 19'd0, hi, ct, xf, nf);
         n_cmp++; if (hi !== 40 || !ct) begin n_bad++; $display("FAIL steady_width f%0d got %0d contig=%0b want 40", f, hi, ct); end
         n_cmp++; if (xf !== 0 || nf !== 1'b1) begin n_bad++; $display("FAIL steady_period f%0d extra_fs=%0d next_fs=%b want 0/1", f, xf, nf); end
      end
   endtask

   task automatic test_midframe_change();
      int hi, xf; bit ct, nf;
      measure_frame(20, 19'd60, hi, ct, xf, nf);
      n_cmp++; if (hi !== 40) begin n_bad++; $display("FAIL mid_change_cur got %0d want 40", hi); end
      n_cmp++; if (duty_active !== 19'd60) begin n_bad++; $display("FAIL mid_change_latch got %0d want 60", duty_active); end
      measure_frame(-1, 19'd0, hi, ct, xf, nf);
      n_cmp++; if (hi !== 60 || !ct) begin n_bad++; $display("FAIL mid_change_next got %0d want 60", hi); end
   endtask

   task automatic test_clamp();
      int hi, xf; bit ct, nf;
      logic [18:0] req [3] = '{19'd5, 19'd300, 19'd10};
      int          w   [3] = '{10, 90, 10};
      bit          cl  [3] = '{1'b1, 1'b1, 1'b0};
      s_duty = req[0];
      measure_frame(-1, 19'd0, hi, ct, xf, nf);
      for (int k = 0; k < 3; k++) begin
         n_cmp++; if (clamped !== cl[k] || duty_active !== 19'(w[k])) begin n_bad++; $display("FAIL clamp_latch req=%0d got duty=%0d cl=%b want %0d/%0b", req[k], duty_active, clamped, w[k], cl[k]); end
         measure_frame(50, (k < 2) ? req[k+1] : req[k], hi, ct, xf, nf);
         n_cmp++; if (hi !== w[k] || !ct) begin n_bad++; $display("FAIL clamp_width req=%0d got %0d want %0d", req[k], hi, w[k]); end
      end
   endtask

   task automatic test_settle();
      int hi, xf; bit ct, nf;
      bit exp_st [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      en = 0;
      @(negedge clk);
      n_cmp++; if (settled !== 1'b0 || s_pulse !== 1'b0) begin n_bad++; $display("FAIL disable_idle got st=%b pulse=%b want 0/0", settled, s_pulse); end
      s_duty = 19'd40; en = 1;
      @(negedge clk);
      for (int f = 0; f < 6; f++) begin
         n_cmp++; if (frame_start !== 1'b1 || settled !== exp_st[f]) begin n_bad++; $display("FAIL settle f%0d got fs=%b st=%b want 1/%0b", f, frame_start, settled, exp_st[f]); end
         measure_frame((f == 2) ? 50 : -1, 19'd41, hi, ct, xf, nf);
      end
   endtask

   task automatic test_enable_drop();
      int hi, xf; bit ct, nf;
      measure_frame(50, 19'd40, hi, ct, xf, nf);
      repeat (15) @(negedge clk);
      n_cmp++; if (s_pulse !== 1'b1) begin n_bad++; $display("FAIL drop_pre got %b want 1", s_pulse); end
      en = 0;
      @(negedge clk);
      n_cmp++; if (s_pulse !== 1'b0 || settled !== 1'b0 || frame_start !== 1'b0) begin n_bad++; $display("FAIL drop_outputs got pulse=%b st=%b fs=%b want 000", s_pulse, settled, frame_start); end
      n_cmp++; if (duty_active !== 19'd40) begin n_bad++; $display("FAIL drop_hold got %0d want 40", duty_active); end
      repeat (120) @(negedge clk);
      n_cmp++; if (s_pulse !== 1'b0 || frame_start !== 1'b0) begin n_bad++; $display("FAIL drop_idle got pulse=%b fs=%b want 00", s_pulse, frame_start); end
      s_duty = 19'd70; en = 1;
      @(negedge clk);
      n_cmp++; if (frame_start !== 1'b1 || duty_active !== 19'd70) begin n_bad++; $display("FAIL reenable got fs=%b duty=%0d want 1/70", frame_start, duty_active); end
      measure_frame(-1, 19'd0, hi, ct, xf, nf);
      n_cmp++; if (hi !== 70 || !ct) begin n_bad++; $display("FAIL reenable_width got %0d want 70", hi); end
   endtask

   task automatic test_random();
      int bad_here = 0;
      for (int i = 0; i < 6000; i++) begin
         n_cmp++;
         if (s_pulse !== m_pulse || frame_start !== m_fs || duty_active !== 19'(m_duty) ||
             clamped !== m_clamped || settled !== m_settled) begin
            n_bad++; bad_here++;
            if (bad_here <= 5)
               $display("FAIL random cyc%0d got p=%b fs=%b d=%0d c=%b s=%b want p=%b fs=%b d=%0d c=%b s=%b",
                        i, s_pulse, frame_start, duty_active, clamped, settled,
                        m_pulse, m_fs, m_duty, m_clamped, m_settled);
         end
         if ($urandom_range(0, 149) == 0) s_duty = 19'($urandom);
         else if ($urandom_range(0, 59) == 0) s_duty = 19'($urandom_range(0, 120));
         if ($urandom_range(0, 399) == 0) en = ~en;
         if (!en && $urandom_range(0, 29) == 0) en = 1'b1;
         @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_steady();
      test_midframe_change();
      test_clamp();
      test_settle();
      test_enable_drop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
